store_queue: RTL and testbench

- Store-drain buffer sitting directly downstream of the per-lane write-enable decoder in the memory stage.
- Accepts one decoded store per cycle: byte address, raw store data, 4-bit DMEM and IMEM lane enables.
- Aligns the data to the enabled lanes and buffers up to DEPTH stores, then drains them in order to the DMEM/IMEM block-RAM write ports.
- IMEM writes wait for a port grant from fetch. A load-hazard flag lets the pipeline stall loads that hit a pending store.

---
 rtl/store_queue.sv | 148 ++++++++++++++
 tb/tb_store_queue.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// In-order store-drain buffer with lane alignment and IMEM grant gating.
// Optional direct-to-output bypass when empty: define STORE_QUEUE_BYPASS_EN.
module store_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_addr,
    input  logic [31:0]      enq_data,
    input  logic [3:0]       enq_dwea,
    input  logic [3:0]       enq_iwea,
    input  logic             imem_grant,
    output logic [29:0]      mem_addr,
    output logic [31:0]      mem_din,
    output logic [3:0]       dmem_we,
    output logic [3:0]       imem_we,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hazard,
    output logic [PTR_W:0]   count
);

    logic [29:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_dwea [DEPTH];
    logic [3:0]       r_iwea [DEPTH];
    logic [DEPTH-1:0] r_vld;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic [29:0]      r_mem_addr;
    logic [31:0]      r_mem_din;
    logic [3:0]       r_dmem_we;
    logic [3:0]       r_imem_we;

    logic [3:0]       w_lanes;
    logic [31:0]      w_aligned;
    logic             w_full;
    logic             w_enq;
    logic             w_byp;
    logic             w_alloc;
    logic             w_drain;
    logic             w_hit;

    assign w_lanes   = enq_dwea | enq_iwea;
    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign enq_ready = !w_full;
    assign w_enq     = enq_valid && !w_full && (w_lanes != 4'b0000);

    // Replicate the source so every enabled lane sees the right bytes.
    always_comb begin
        w_aligned = enq_data;
        case (w_lanes)
            4'b1000, 4'b0100, 4'b0010, 4'b0001:
                w_aligned = {4{enq_data[7:0]}};
            4'b1100, 4'b1010, 4'b1001,
            4'b0110, 4'b0101, 4'b0011:
                w_aligned = {2{enq_data[15:0]}};
            default:
                w_aligned = enq_data;
        endcase
    end

`ifdef STORE_QUEUE_BYPASS_EN
    assign w_byp = w_enq && (r_count == '0) &&
                   ((enq_iwea == 4'b0000) || imem_grant);
`else
    assign w_byp = 1'b0;
`endif

    assign w_alloc = w_enq && !w_byp;
    assign w_drain = (r_count != '0) &&
                     ((r_iwea[r_head] == 4'b0000) || imem_grant);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_alloc) begin
                r_addr[r_tail] <= enq_addr[31:2];
                r_data[r_tail] <= w_aligned;
                r_dwea[r_tail] <= enq_dwea;
                r_iwea[r_tail] <= enq_iwea;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            case ({w_alloc, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Strobes last one cycle; address and data hold between writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_dmem_we  <= '0;
            r_imem_we  <= '0;
        end else if (w_drain) begin
            r_mem_addr <= r_addr[r_head];
            r_mem_din  <= r_data[r_head];
            r_dmem_we  <= r_dwea[r_head];
            r_imem_we  <= r_iwea[r_head];
        end else if (w_byp) begin
            r_mem_addr <= enq_addr[31:2];
            r_mem_din  <= w_aligned;
            r_dmem_we  <= enq_dwea;
            r_imem_we  <= enq_iwea;
        end else begin
            r_dmem_we  <= '0;
            r_imem_we  <= '0;
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == ld_addr[31:2]))
                w_hit = 1'b1;
        end
        if (((r_dmem_we | r_imem_we) != 4'b0000) &&
            (r_mem_addr == ld_addr[31:2]))
            w_hit = 1'b1;
    end

    assign ld_hazard = ld_valid && w_hit;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign dmem_we   = r_dmem_we;
    assign imem_we   = r_imem_we;
    assign count     = r_count;

endmodule

// File: tb/tb_store_queue.sv
// Directed self-checking bench for store_queue (default build).
`timescale 1ns/1ps
module tb_store_queue;

    logic        clk;
    logic        rst;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_addr;
    logic [31:0] enq_data;
    logic [3:0]  enq_dwea;
    logic [3:0]  enq_iwea;
    logic        imem_grant;
    logic [29:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  dmem_we;
    logic [3:0]  imem_we;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    store_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_data(enq_data),
        .enq_dwea(enq_dwea), .enq_iwea(enq_iwea),
        .imem_grant(imem_grant),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .dmem_we(dmem_we), .imem_we(imem_we),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_hazard(ld_hazard), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_valid = 1'b0;
        enq_dwea  = 4'b0000;
        enq_iwea  = 4'b0000;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] dw, input logic [3:0] iw);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        enq_dwea  = dw;
        enq_iwea  = iw;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        push(32'h1000_0000, 32'hDEAD_BEEF, 4'b1111, 4'b0000);
        tick();
        tick();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if (dmem_we !== 4'b0 || imem_we !== 4'b0) begin
            errors++;
            $display("FAIL reset_we got %b/%b want 0000/0000",
                     dmem_we, imem_we);
        end
        checks++;
        if (enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", enq_ready);
        end
        checks++;
        if (mem_addr !== 30'h0 || mem_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got %h/%h want 0/0", mem_addr, mem_din);
        end
        idle();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sb();
        push(32'h1000_0006, 32'h0000_00AB, 4'b0010, 4'b0000);
        tick();
        idle();
        checks++;
        if (count !== 3'd1 || dmem_we !== 4'b0000) begin
            errors++;
            $display("FAIL sb_queued got cnt=%0d we=%b want 1/0000",
                     count, dmem_we);
        end
        tick();
        checks++;
        if (dmem_we !== 4'b0010 || imem_we !== 4'b0000) begin
            errors++;
            $display("FAIL sb_we got %b/%b want 0010/0000", dmem_we, imem_we);
        end
        checks++;
        if (mem_addr !== 30'h0400_0001) begin
            errors++;
            $display("FAIL sb_addr got %h want 04000001", mem_addr);
        end
        checks++;
        if (mem_din !== 32'hABAB_ABAB) begin
            errors++;
            $display("FAIL sb_din got %h want ababab ab", mem_din);
        end
        tick();
        checks++;
        if (dmem_we !== 4'b0000 || mem_addr !== 30'h0400_0001 ||
            mem_din !== 32'hABAB_ABAB || count !== 3'd0) begin
            errors++;
            $display("FAIL sb_after got we=%b a=%h d=%h c=%0d want 0000/04000001/abababab/0",
                     dmem_we, mem_addr, mem_din, count);
        end
    endtask

    task automatic test_imem_block();
        imem_grant = 1'b0;
        push(32'h2000_0000, 32'h1122_3344, 4'b0000, 4'b1111);
        tick();
        push(32'h1000_0000, 32'h5566_7788, 4'b1111, 4'b0000);
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (count !== 3'd2 || dmem_we !== 4'b0 || imem_we !== 4'b0) begin
                errors++;
                $display("FAIL imem_stall[%0d] got c=%0d d=%b i=%b want 2/0000/0000",
                         i, count, dmem_we, imem_we);
            end
        end
        ld_valid = 1'b1;
        ld_addr  = 32'h2000_0003;
        #1;
        checks++;
        if (ld_hazard !== 1'b1) begin
            errors++;
            $display("FAIL imem_hazard got %b want 1", ld_hazard);
        end
        ld_valid = 1'b0;
        imem_grant = 1'b1;
        tick();
        imem_grant = 1'b0;
        checks++;
        if (imem_we !== 4'b1111 || dmem_we !== 4'b0000 ||
            mem_addr !== 30'h0800_0000 || mem_din !== 32'h1122_3344) begin
            errors++;
            $display("FAIL imem_write got i=%b d=%b a=%h din=%h want 1111/0000/08000000/11223344",
                     imem_we, dmem_we, mem_addr, mem_din);
        end
        tick();
        checks++;
        if (dmem_we !== 4'b1111 || imem_we !== 4'b0000 ||
            mem_addr !== 30'h0400_0000 || mem_din !== 32'h5566_7788 ||
            count !== 3'd0) begin
            errors++;
            $display("FAIL imem_then_dmem got d=%b i=%b a=%h din=%h c=%0d want 1111/0000/04000000/55667788/0",
                     dmem_we, imem_we, mem_addr, mem_din, count);
        end
        tick();
    endtask

    task automatic test_full();
        logic [29:0] exp_a;
        imem_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h2000_0000 + 32'(i * 4), 32'(i), 4'b0000, 4'b1111);
            tick();
        end
        checks++;
        if (count !== 3'd4 || enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_4 got c=%0d rdy=%b want 4/0", count, enq_ready);
        end
        push(32'h2000_0010, 32'h4, 4'b0000, 4'b1111);
        tick();
        checks++;
        if (count !== 3'd4 || enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got c=%0d rdy=%b want 4/0", count, enq_ready);
        end
        imem_grant = 1'b1;
        tick();
        imem_grant = 1'b0;
        checks++;
        if (count !== 3'd3 || imem_we !== 4'b1111 ||
            mem_addr !== 30'h0800_0000 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_drain got c=%0d i=%b a=%h rdy=%b want 3/1111/08000000/1",
                     count, imem_we, mem_addr, enq_ready);
        end
        tick();
        idle();
        checks++;
        if (count !== 3'd4 || imem_we !== 4'b0000) begin
            errors++;
            $display("FAIL full_fifth got c=%0d i=%b want 4/0000", count, imem_we);
        end
        imem_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_a = 30'h0800_0000 + 30'(i);
            checks++;
            if (imem_we !== 4'b1111 || mem_addr !== exp_a ||
                mem_din !== 32'(i) || count !== 3'(4 - i)) begin
                errors++;
                $display("FAIL full_order[%0d] got i=%b a=%h d=%h c=%0d want 1111/%h/%h/%0d",
                         i, imem_we, mem_addr, mem_din, count,
                         exp_a, 32'(i), 4 - i);
            end
        end
        imem_grant = 1'b0;
        tick();
    endtask

    task automatic test_hazard();
        push(32'h1000_0012, 32'h0000_BEEF, 4'b0011, 4'b0000);
        tick();
        idle();
        ld_valid = 1'b1;
        ld_addr  = 32'h1000_0010;
        #1;
        checks++;
        if (ld_hazard !== 1'b1) begin
            errors++;
            $display("FAIL hz_entry got %b want 1", ld_hazard);
        end
        ld_addr = 32'h1000_0014;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hz_miss got %b want 0", ld_hazard);
        end
        ld_addr = 32'h1000_0010;
        tick();
        checks++;
        if (ld_hazard !== 1'b1 || dmem_we !== 4'b0011 ||
            mem_din !== 32'hBEEF_BEEF || mem_addr !== 30'h0400_0004) begin
            errors++;
            $display("FAIL hz_outreg got hz=%b we=%b d=%h a=%h want 1/0011/beefbeef/04000004",
                     ld_hazard, dmem_we, mem_din, mem_addr);
        end
        ld_valid = 1'b0;
        #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hz_novalid got %b want 0", ld_hazard);
        end
        ld_valid = 1'b1;
        tick();
        checks++;
        if (ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hz_retired got %b want 0", ld_hazard);
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_zero_enable();
        push(32'h1000_0020, 32'h1234_5678, 4'b0000, 4'b0000);
        #1;
        checks++;
        if (enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready got %b want 1", enq_ready);
        end
        tick();
        idle();
        tick();
        checks++;
        if (count !== 3'd0 || dmem_we !== 4'b0 || imem_we !== 4'b0) begin
            errors++;
            $display("FAIL zero_drop got c=%0d d=%b i=%b want 0/0000/0000",
                     count, dmem_we, imem_we);
        end
    endtask

    task automatic test_back_to_back();
        push(32'h1000_0100, 32'hAAAA_0001, 4'b1111, 4'b0000);
        tick();
        push(32'h1000_0104, 32'hBBBB_0002, 4'b1111, 4'b0000);
        tick();
        checks++;
        if (mem_addr !== 30'h0400_0040 || dmem_we !== 4'b1111 ||
            count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_0 got a=%h we=%b c=%0d want 04000040/1111/1",
                     mem_addr, dmem_we, count);
        end
        push(32'h1000_0108, 32'h0000_00C3, 4'b0100, 4'b0000);
        tick();
        idle();
        checks++;
        if (mem_addr !== 30'h0400_0041 || mem_din !== 32'hBBBB_0002 ||
            count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_1 got a=%h d=%h c=%0d want 04000041/bbbb0002/1",
                     mem_addr, mem_din, count);
        end
        tick();
        checks++;
        if (mem_addr !== 30'h0400_0042 || mem_din !== 32'hC3C3_C3C3 ||
            dmem_we !== 4'b0100 || count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_2 got a=%h d=%h we=%b c=%0d want 04000042/c3c3c3c3/0100/0",
                     mem_addr, mem_din, dmem_we, count);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        imem_grant = 1'b0;
        push(32'h2000_0040, 32'h1, 4'b0000, 4'b1111);
        tick();
        push(32'h1000_0040, 32'h2, 4'b1111, 4'b0000);
        tick();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        imem_grant = 1'b1;
        tick();
        checks++;
        if (count !== 3'd0 || imem_we !== 4'b0 || dmem_we !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid got c=%0d i=%b d=%b want 0/0000/0000",
                     count, imem_we, dmem_we);
        end
        tick();
        checks++;
        if (imem_we !== 4'b0 || dmem_we !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_late got i=%b d=%b want 0000/0000",
                     imem_we, dmem_we);
        end
        imem_grant = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        imem_grant = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = 32'h0;
        enq_addr   = 32'h0;
        enq_data   = 32'h0;
        idle();
        test_reset();
        test_sb();
        test_imem_block();
        test_full();
        test_hazard();
        test_zero_enable();
        test_back_to_back();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
